// File: rtl/seq_stream_pkg.sv
// Shared definitions for the serial pattern streaming controller.
//   state_t         : controller FSM states
//   DEF_PAT_LEN     : default pattern length in bits
//   DEF_PATTERN     : default pattern, oldest bit in the MSB
package seq_stream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int                     DEF_PAT_LEN = 3;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 3'b101;

endpackage

// File: rtl/seq_stream_ctrl_if.sv
// Parallel word handshake between a word producer and seq_stream_ctrl.
//   in_data  : parallel word (producer -> controller)
//   in_valid : in_data is valid (producer -> controller)
//   in_ready : controller accepts a word this cycle (controller -> producer)
// A word transfers on any rising edge where in_valid && in_ready.
interface seq_stream_ctrl_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/seq_stream_ctrl_pattern_det.sv
// Overlapping serial pattern detector.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   clr     : synchronous clear of history, fill and match
//   bit_vld : bit_in carries a new stream bit this cycle
//   bit_in  : serial stream bit
//   hit     : combinational match for the bit presented this cycle
//   match   : one-cycle pulse, registered copy of hit
// History survives matches, idle gaps and word boundaries; only rst or clr
// clears it, so overlapping and cross-word occurrences are all reported.
module pattern_det
  import seq_stream_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_vld,
  input  logic bit_in,
  output logic hit,
  output logic match
);

  localparam int FILL_W = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] window;

  // Candidate window: stored history followed by the bit arriving now.
  assign window = {hist, bit_in};

  // The top-level counter needs this so it steps on the same edge that
  // raises match.
  assign hit = bit_vld && (fill == FILL_MAX) && (window == PATTERN);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (bit_vld) begin
        hist <= window[PAT_LEN-2:0];
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_stream_ctrl.sv
// Word-to-bit streaming front end for the serial pattern detector.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   enable    : allow new words; a word in progress always completes
//   clr       : synchronous clear of history, fill, count and word in progress
//   bus       : slave side of the in_data/in_valid/in_ready handshake
//   match     : one-cycle pulse per detected occurrence
//   match_cnt : saturating match count
//   busy      : a word is being serialized
// Words are serialized MSB first, one bit per clock. in_ready is
// combinational so a word can be taken on the last bit of the previous one,
// keeping the bit stream gap-free.
module seq_stream_ctrl
  import seq_stream_pkg::*;
#(
  parameter int                 DATA_W  = 8,
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clr,
  seq_stream_ctrl_if.slave   bus,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shreg;
  logic              last_bit;
  logic              accept;
  logic              bit_vld;
  logic              hit;

  assign last_bit     = (state == SHIFT) && (idx == IDX_LAST);
  assign bus.in_ready = !rst && !clr && enable && ((state == IDLE) || last_bit);
  assign accept       = bus.in_valid && bus.in_ready;
  assign bit_vld      = (state == SHIFT);
  assign busy         = (state == SHIFT);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge value of every other; blocking here would make the
  // result depend on statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= IDLE;
      idx   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            idx   <= '0;
            shreg <= bus.in_data;
          end
        end
        SHIFT: begin
          if (idx == IDX_LAST) begin
            idx <= '0;
            if (accept) begin
              shreg <= bus.in_data;
            end else begin
              state <= IDLE;
              shreg <= '0;
            end
          end else begin
            idx   <= idx + 1'b1;
            shreg <= {shreg[DATA_W-2:0], 1'b0};
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  pattern_det #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_det (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .bit_vld (bit_vld),
    .bit_in  (shreg[DATA_W-1]),
    .hit     (hit),
    .match   (match)
  );

  // Steps on the same edge that raises match; holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != '1)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Directed bench for seq_stream_ctrl. Two instances share the stimulus:
// dut1 with an 8-bit match counter and dut2 with a 2-bit counter for the
// saturation case.
module tb_seq_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       clr;
  logic [7:0] in_data;
  logic       in_valid;

  logic       match1, match2, busy1, busy2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_stream_ctrl_if #(.DATA_W(8)) bus1 ();
  seq_stream_ctrl_if #(.DATA_W(8)) bus2 ();

  assign bus1.in_data  = in_data;
  assign bus1.in_valid = in_valid;
  assign bus2.in_data  = in_data;
  assign bus2.in_valid = in_valid;

  seq_stream_ctrl #(.DATA_W(8), .CNT_W(8)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clr       (clr),
    .bus       (bus1),
    .match     (match1),
    .match_cnt (cnt1),
    .busy      (busy1)
  );

  seq_stream_ctrl #(.DATA_W(8), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clr       (clr),
    .bus       (bus2),
    .match     (match2),
    .match_cnt (cnt2),
    .busy      (busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word while the controller is ready; returns in the cycle
  // where bit 0 of the word is presented.
  task automatic send_word(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    #1;
    check("send_ready", {31'b0, bus1.in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Advance n cycles; bit i of each mask is match seen after the (i+1)th edge.
  task automatic run_bits(input int n, output logic [7:0] m1, output logic [7:0] m2,
                          output logic busy_all);
    m1 = '0;
    m2 = '0;
    busy_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      busy_all = busy_all & busy1;
      tick();
      m1[i] = match1;
      m2[i] = match2;
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  logic [7:0] m1, m2, m1b, m2b;
  logic       ball;

  initial begin
    rst = 1'b1; enable = 1'b1; clr = 1'b0; in_data = '0; in_valid = 1'b0;

    // Reset held two cycles.
    tick();
    tick();
    check("rst_match",  {31'b0, match1}, 32'd0);
    check("rst_cnt",    {24'b0, cnt1},   32'd0);
    check("rst_busy",   {31'b0, busy1},  32'd0);
    check("rst_ready",  {31'b0, bus1.in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'b0, bus1.in_ready}, 32'd1);

    // 0xA5: matches on bits 2 and 7.
    send_word(8'hA5);
    check("a5_busy", {31'b0, busy1}, 32'd1);
    run_bits(8, m1, m2, ball);
    check("a5_mask", {24'b0, m1}, 32'h84);
    check("a5_cnt",  {24'b0, cnt1}, 32'd2);
    check("a5_busy_end", {31'b0, busy1}, 32'd0);

    // 0x2A from clean history: matches on bits 4 and 6.
    do_clr();
    check("clr_cnt", {24'b0, cnt1}, 32'd0);
    send_word(8'h2A);
    run_bits(8, m1, m2, ball);
    check("2a_mask", {24'b0, m1}, 32'h50);
    check("2a_cnt",  {24'b0, cnt1}, 32'd2);

    // 0x01 then 0x40 back to back: one cross-word match on bit 1 of 0x40.
    send_word(8'h01);
    run_bits(7, m1, m2, ball);
    in_data  = 8'h40;
    in_valid = 1'b1;
    #1;
    check("b2b_ready", {31'b0, bus1.in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_match_bit7", {31'b0, match1}, 32'd0);
    check("b2b_busy_gap", {31'b0, busy1}, 32'd1);
    check("01_mask", {24'b0, m1}, 32'h00);
    check("01_busy_all", {31'b0, ball}, 32'd1);
    run_bits(8, m1, m2, ball);
    check("40_mask", {24'b0, m1}, 32'h02);
    check("40_busy_all", {31'b0, ball}, 32'd1);
    check("40_cnt", {24'b0, cnt1}, 32'd3);
    check("40_busy_end", {31'b0, busy1}, 32'd0);

    // Saturation: dut2 has a 2-bit counter.
    do_clr();
    send_word(8'hAA);
    run_bits(8, m1, m2, ball);
    check("aa1_mask2", {24'b0, m2}, 32'h54);
    check("aa1_cnt2",  {30'b0, cnt2}, 32'd3);
    send_word(8'hAA);
    run_bits(8, m1, m2, ball);
    check("aa2_mask2", {24'b0, m2}, 32'h55);
    check("aa2_cnt2",  {30'b0, cnt2}, 32'd3);
    check("aa2_cnt1",  {24'b0, cnt1}, 32'd7);

    // clr in the cycle bit 2 of 0xA5 is presented.
    do_clr();
    send_word(8'hA5);
    tick();
    tick();
    clr = 1'b1;
    #1;
    check("clr_ready", {31'b0, bus1.in_ready}, 32'd0);
    tick();
    clr = 1'b0;
    check("clr_match", {31'b0, match1}, 32'd0);
    check("clr_cnt2",  {24'b0, cnt1}, 32'd0);
    check("clr_busy",  {31'b0, busy1}, 32'd0);
    #1;
    check("clr_ready_after", {31'b0, bus1.in_ready}, 32'd1);

    // enable dropped in cycle t+2: word still completes and counts.
    send_word(8'hA5);
    run_bits(1, m1, m2, ball);
    enable = 1'b0;
    run_bits(7, m1b, m2b, ball);
    check("en_mask", {24'b0, m1b[6:0], m1[0]}, 32'h84);
    check("en_cnt",  {24'b0, cnt1}, 32'd2);
    check("en_ready_low", {31'b0, bus1.in_ready}, 32'd0);

    // Valid held with enable low: no accept.
    in_data  = 8'h2A;
    in_valid = 1'b1;
    tick();
    tick();
    check("stall_busy", {31'b0, busy1}, 32'd0);
    check("stall_ready", {31'b0, bus1.in_ready}, 32'd0);
    enable = 1'b1;
    #1;
    check("en_ready_same", {31'b0, bus1.in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("en_accept_busy", {31'b0, busy1}, 32'd1);
    run_bits(8, m1, m2, ball);
    check("stall_2a_mask", {24'b0, m1}, 32'h50);
    check("stall_2a_cnt",  {24'b0, cnt1}, 32'd4);

    // rst mid-word: word lost, no partial output afterwards.
    send_word(8'hFF);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_busy", {31'b0, busy1}, 32'd0);
    check("mid_rst_cnt",  {24'b0, cnt1}, 32'd0);
    rst = 1'b0;
    run_bits(3, m1, m2, ball);
    check("mid_rst_mask", {24'b0, m1}, 32'h00);
    check("mid_rst_busy2", {31'b0, busy1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_stream_ctrl.md
# seq_stream_ctrl

Streaming controller that feeds the serial pattern detector from a parallel word source. It accepts DATA_W-bit words over a valid/ready handshake and serializes them MSB-first into an internal overlapping pattern detector, one bit per clock. It reports each match as a one-cycle pulse and keeps a saturating match count. It sits between a byte/word producer (UART RX, FIFO, CPU register) and downstream event logic.

## Interface
- DATA_W, 8: input word width, ≥ 2.
- PAT_LEN, 3: pattern length in bits, 2..DATA_W.
- PATTERN, 3'b101: bit pattern, oldest bit in MSB.
- CNT_W, 8: match counter width.

Reset is synchronous, active-high, on rst. Single clock clk.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  allow new words; the word in progress always completes.
- clr  in  1  synchronous clear of history, fill, count, and any word in progress.
- in_data  in  DATA_W  parallel word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller can accept a word this cycle.
- match  out  1  one-cycle pulse per detected pattern occurrence.
- match_cnt  out  CNT_W  saturating count of matches.
- busy  out  1  a word is being serialized.

## Operation
- FSM states:
  - IDLE: go to SHIFT on accept, else stay.
  - SHIFT: bit index idx counts 0..DATA_W-1. At idx = DATA_W-1, go to SHIFT with idx = 0 if a word is accepted, else go to IDLE.
- Accept is in_valid && in_ready.
- in_ready = !rst && !clr && enable && (state == IDLE || idx == DATA_W-1). This is combinational from state and inputs, so back-to-back words give a gap-free bit stream.
- On accept, in_data loads into the shift register. In each SHIFT cycle the current MSB is presented to the detector with a bit strobe, then the register shifts left.
- Detector sub-module:
  - hist holds the last PAT_LEN-1 bits.
  - fill is a saturating count of bits seen, up to PAT_LEN-1.
  - match_comb = (fill == PAT_LEN-1) && ({hist, bit} == PATTERN).
  - Overlapping detection is required; hist is not cleared on a match.
  - History persists across word boundaries and across IDLE gaps. Only rst or clr clears it.
- match is registered from match_comb. match_cnt increments on the same edge that sets match, and saturates at 2^CNT_W-1 (no wrap).
- busy = (state == SHIFT).
- clr: state goes to IDLE, idx 0, hist 0, fill 0, match_cnt 0, match 0 on the next edge. clr has priority over everything except rst. A bit presented in the clr cycle does not produce a match.
- enable low only blocks new accepts. A word already in SHIFT finishes and its matches are counted.
- Reset values: state IDLE, idx 0, shift register 0, hist 0, fill 0, match 0, match_cnt 0, busy 0. in_ready is 0 while rst is high.

## Timing
- Word accepted on edge t. Bit k (k = 0 is the MSB) is presented during cycle t+1+k.
- A match on bit k shows match = 1 and the updated match_cnt in cycle t+2+k.
- Throughput is one word per DATA_W cycles with continuous in_valid. No bubble between words.
- Last word bit presented in cycle t+DATA_W. busy falls in cycle t+DATA_W+1 if no new word is accepted.
- rst asserted mid-word: the word is lost and all state clears on that edge. There is no partial-word output afterwards.
- Detection latency from bit presentation to match is 1 cycle, constant.

## Structure
- Package seq_stream_pkg holds the FSM state enum (IDLE, SHIFT) and the default PATTERN/PAT_LEN constants.
- One sub-module, pattern_det, contains hist, fill, the comparator and the registered match. Ports: clk, rst, clr, bit_vld, bit_in, match.
- Top level holds the FSM, shift register, idx counter, handshake and saturating counter.

## Test plan
Defaults unless noted: DATA_W=8, PATTERN=101.

- Reset: hold rst 2 cycles, then release. All outputs 0 during reset; after release, in_ready = 1 with enable = 1.
- Single word 0xA5 (10100101): matches on bits 2 and 7. Pulses in cycles t+4 and t+9; match_cnt = 2.
- Overlap and cross-word:
  - 0x2A alone gives matches on bits 4 and 6 (count 2).
  - Then 0x01 followed back-to-back by 0x40 gives one match on bit 1 of 0x40; total count 3.
  - No busy gap between the two words.
- Saturation, CNT_W=2: send 0xAA twice. The first word gives 3 matches (count 3). The second gives match pulses but match_cnt stays 3.
- clr mid-word:
  - Accept 0xA5, assert clr in cycle t+3, the same cycle bit 2 is presented.
  - Required: no match pulse at t+4, count 0, state IDLE, busy 0, and in_ready low during the clr cycle.
- enable and handshake stall:
  - Drop enable in cycle t+2 of a word: the word completes and its matches count; in_ready stays 0 afterwards.
  - Hold in_valid high with enable low: no accept.
  - Raise enable: the word is accepted in the same cycle.
